// File: rtl/mips_defs.sv
// Shared constants for the pipelined MIPS core. The fetch stage and the
// later pipeline registers use these constants.
package mips_defs;

  localparam int          WORD_W        = 32;
  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

  // Force an address onto a word boundary by clearing its byte-offset bits
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register with asynchronous active-low reset, a load
// enable and a synchronous clear. The clear only acts when the enable is
// high, so a stall always wins over a flush.
module pipe_reg_en_clr #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register holds on !en, loads CLR_VAL on clr, otherwise captures d
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= RST_VAL;
    else if (en) begin
      if (clr)
        q <= CLR_VAL;
      else
        q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus the IF/ID pipeline register. Holds the PC,
// picks the next PC from sequential/branch/jump targets and registers the
// fetched word into Decode.
module fetch_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcSrcD,
  input  logic [31:0] pcBranchD,
  input  logic        jumpD,
  input  logic [31:0] pcJumpD,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemRdata,
  output logic [31:0] instrD,
  output logic [31:0] pcPlus4D,
  output logic        validD,
  output logic        alignErr
);

  logic [31:0] pcF;
  logic [31:0] pcPlus4F;
  logic [31:0] rawTarget;
  logic [31:0] pcNext;
  logic        misaligned;

  assign pcPlus4F = pcF + PC_INC;
  assign imemAddr = pcF;

  // Next-PC select: jump beats branch beats sequential; redirect targets are word-aligned
  always_comb begin
    rawTarget  = pcPlus4F;
    misaligned = 1'b0;
    if (jumpD)
      rawTarget = pcJumpD;
    else if (pcSrcD)
      rawTarget = pcBranchD;
    if (jumpD || pcSrcD)
      misaligned = (rawTarget[1:0] != 2'b00);
    pcNext = word_align(rawTarget);
  end

  // Sticky alignment error, only raised when the bad target is actually loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      alignErr <= 1'b0;
    else if (misaligned && !stallF)
      alignErr <= 1'b1;
  end

  pipe_reg_en_clr #(
    .WIDTH  (WORD_W),
    .RST_VAL(RESET_PC),
    .CLR_VAL('0)
  ) u_pc_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (!stallF),
    .clr  (1'b0),
    .d    (pcNext),
    .q    (pcF)
  );

  pipe_reg_en_clr #(
    .WIDTH  (WORD_W),
    .RST_VAL(NOP_INSTR),
    .CLR_VAL(NOP_INSTR)
  ) u_instr_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (!stallD),
    .clr  (flushD),
    .d    (imemRdata),
    .q    (instrD)
  );

  pipe_reg_en_clr #(
    .WIDTH  (WORD_W),
    .RST_VAL('0),
    .CLR_VAL('0)
  ) u_pcplus4_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (!stallD),
    .clr  (flushD),
    .d    (pcPlus4F),
    .q    (pcPlus4D)
  );

  pipe_reg_en_clr #(
    .WIDTH  (1),
    .RST_VAL(1'b0),
    .CLR_VAL(1'b0)
  ) u_valid_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (!stallD),
    .clr  (flushD),
    .d    (1'b1),
    .q    (validD)
  );

endmodule
